pipeline_hazard_controller: RTL

- Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB): generates PC and pipeline-register write enables, bubble/flush controls and gated reg/RAM write strobes.
- Tracks per-stage valid bits; resolves RAW data hazards by stalling, MEM-resolved branches by flushing, and slow RAM accesses by freezing.
- Supports a debug halt/drain/resume sequence. Replaces the free-running stage sequencing in the CPU top.

---
 rtl/pipeline_hazard_controller_pkg.sv | 21 ++
 rtl/pipeline_hazard_controller_hazard_detect.sv | 31 +++
 rtl/pipeline_hazard_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic PC_SEL_SEQ       = 1'b0;
    localparam logic PC_SEL_REDIRECT  = 1'b1;
    localparam logic REG_WRITE_ENABLE = 1'b1;
    localparam logic RAM_WRITE_ENABLE = 1'b1;

    // x0 is hardwired to zero, so it can never be the source of a hazard.
    function automatic logic rd_match(input logic [4:0] rs, input logic [4:0] rd);
        return (rd != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational RAW hazard detection between the ID sources and the EX/MEM/WB destinations.
module pipeline_hazard_controller_hazard_detect
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [4:0] rs1_address,
    input  logic [4:0] rs2_address,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] ex_rd_address,
    input  logic [4:0] mem_rd_address,
    input  logic [4:0] wb_rd_address,
    input  logic       ex_writes,
    input  logic       mem_writes,
    input  logic       wb_writes,
    output logic       raw_hazard
);

    logic rs1_hit;
    logic rs2_hit;

    // No forwarding and no write-through regfile, so a WB producer stalls as well.
    assign rs1_hit = uses_rs1 & ((ex_writes  & rd_match(rs1_address, ex_rd_address))  |
                                 (mem_writes & rd_match(rs1_address, mem_rd_address)) |
                                 (wb_writes  & rd_match(rs1_address, wb_rd_address)));
    assign rs2_hit = uses_rs2 & ((ex_writes  & rd_match(rs2_address, ex_rd_address))  |
                                 (mem_writes & rd_match(rs2_address, mem_rd_address)) |
                                 (wb_writes  & rd_match(rs2_address, wb_rd_address)));

    assign raw_hazard = rs1_hit | rs2_hit;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: stall/flush/freeze control, valid tracking and debug halt/drain/resume.
// Optional performance counters are enabled with `define PIPELINE_PERF_COUNTERS_EN.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
`ifdef PIPELINE_PERF_COUNTERS_EN
    , parameter int CNT_WIDTH = 32
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] id_rs1_address,
    input  logic [4:0] id_rs2_address,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd_address,
    input  logic [4:0] mem_rd_address,
    input  logic [4:0] wb_rd_address,
    input  logic       ex_reg_wren,
    input  logic       mem_reg_wren,
    input  logic       wb_reg_wren,
    input  logic       mem_redirect,
    input  logic       mem_ram_access,
    input  logic       mem_ram_write,
    input  logic       ram_ready,
    input  logic       halt_req,
    input  logic       resume,
    output logic       pc_wren,
    output logic       if_id_wren,
    output logic       id_ex_wren,
    output logic       ex_mem_wren,
    output logic       mem_wb_wren,
    output logic       pc_sel,
    output logic       id_ex_bubble,
    output logic       mem_wb_bubble,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       reg_wren,
    output logic       ram_wren,
    output logic       halted
`ifdef PIPELINE_PERF_COUNTERS_EN
    , output logic [CNT_WIDTH-1:0] cnt_retired
    , output logic [CNT_WIDTH-1:0] cnt_stall
    , output logic [CNT_WIDTH-1:0] cnt_memwait
    , output logic [CNT_WIDTH-1:0] cnt_flush
`endif
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t             state, state_next;
    logic               v_id, v_ex, v_mem, v_wb;
    logic               v_id_next, v_ex_next, v_mem_next, v_wb_next;
    logic [DRAIN_W-1:0] drain_cnt, drain_next;
    logic               raw_hazard;
    logic               memwait, redirect, stall, active;

    pipeline_hazard_controller_hazard_detect u_hazard_detect (
        .rs1_address    (id_rs1_address),
        .rs2_address    (id_rs2_address),
        .uses_rs1       (id_uses_rs1),
        .uses_rs2       (id_uses_rs2),
        .ex_rd_address  (ex_rd_address),
        .mem_rd_address (mem_rd_address),
        .wb_rd_address  (wb_rd_address),
        .ex_writes      (v_ex & ex_reg_wren),
        .mem_writes     (v_mem & mem_reg_wren),
        .wb_writes      (v_wb & wb_reg_wren),
        .raw_hazard     (raw_hazard)
    );

    // A redirect cannot be taken until its own RAM access has completed.
    assign memwait  = v_mem & mem_ram_access & ~ram_ready;
    assign redirect = v_mem & mem_redirect & ~memwait;
    assign stall    = raw_hazard & v_id;
    assign active   = (state == RUN) || (state == DRAIN);

    assign reg_wren = (active && v_wb && wb_reg_wren) ? REG_WRITE_ENABLE : ~REG_WRITE_ENABLE;
    assign ram_wren = (active && v_mem && mem_ram_access && mem_ram_write && ram_ready)
                      ? RAM_WRITE_ENABLE : ~RAM_WRITE_ENABLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            v_id      <= 1'b0;
            v_ex      <= 1'b0;
            v_mem     <= 1'b0;
            v_wb      <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            v_id      <= v_id_next;
            v_ex      <= v_ex_next;
            v_mem     <= v_mem_next;
            v_wb      <= v_wb_next;
            drain_cnt <= drain_next;
        end
    end

    always_comb begin
        pc_wren       = 1'b0;
        if_id_wren    = 1'b0;
        id_ex_wren    = 1'b0;
        ex_mem_wren   = 1'b0;
        mem_wb_wren   = 1'b0;
        pc_sel        = PC_SEL_SEQ;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        halted        = 1'b0;
        state_next    = state;
        drain_next    = drain_cnt;
        v_id_next     = v_id;
        v_ex_next     = v_ex;
        v_mem_next    = v_mem;
        v_wb_next     = v_wb;

        unique case (state)
            INIT: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                v_id_next    = 1'b0;
                v_ex_next    = 1'b0;
                v_mem_next   = 1'b0;
                v_wb_next    = 1'b0;
                state_next   = RUN;
            end
            RUN, DRAIN: begin
                if (memwait) begin
                    mem_wb_wren   = 1'b1;
                    mem_wb_bubble = 1'b1;
                    v_wb_next     = 1'b0;
                end else if (redirect) begin
                    pc_wren      = 1'b1;
                    pc_sel       = PC_SEL_REDIRECT;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    mem_wb_wren  = 1'b1;
                    v_id_next    = 1'b0;
                    v_ex_next    = 1'b0;
                    v_mem_next   = 1'b0;
                    v_wb_next    = v_mem;
                end else if (stall) begin
                    id_ex_wren   = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_wren  = 1'b1;
                    mem_wb_wren  = 1'b1;
                    v_ex_next    = 1'b0;
                    v_mem_next   = v_ex;
                    v_wb_next    = v_mem;
                end else begin
                    if_id_wren  = 1'b1;
                    id_ex_wren  = 1'b1;
                    ex_mem_wren = 1'b1;
                    mem_wb_wren = 1'b1;
                    v_ex_next   = v_id;
                    v_mem_next  = v_ex;
                    v_wb_next   = v_mem;
                    // While draining, fetch is stopped and IF/ID takes a bubble instead.
                    if (state == RUN) begin
                        pc_wren   = 1'b1;
                        v_id_next = 1'b1;
                    end else begin
                        if_id_flush = 1'b1;
                        v_id_next   = 1'b0;
                    end
                end

                if (state == RUN) begin
                    if (halt_req) begin
                        state_next = DRAIN;
                        drain_next = DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end else if (!halt_req) begin
                    state_next = RUN;
                end else if (!memwait) begin
                    if (drain_cnt == '0) begin
                        state_next = HALTED;
                    end else begin
                        drain_next = drain_cnt - DRAIN_W'(1);
                    end
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

`ifdef PIPELINE_PERF_COUNTERS_EN
    logic ev_retired, ev_stall, ev_memwait, ev_flush;

    assign ev_retired = active & v_wb & mem_wb_wren;
    assign ev_stall   = active & ~memwait & ~redirect & stall;
    assign ev_memwait = active & memwait;
    assign ev_flush   = active & redirect;

    // Counters saturate rather than wrap; HALTED produces no events, so they freeze there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_retired <= '0;
            cnt_stall   <= '0;
            cnt_memwait <= '0;
            cnt_flush   <= '0;
        end else begin
            if (ev_retired && (cnt_retired != '1)) cnt_retired <= cnt_retired + CNT_WIDTH'(1);
            if (ev_stall   && (cnt_stall   != '1)) cnt_stall   <= cnt_stall   + CNT_WIDTH'(1);
            if (ev_memwait && (cnt_memwait != '1)) cnt_memwait <= cnt_memwait + CNT_WIDTH'(1);
            if (ev_flush   && (cnt_flush   != '1)) cnt_flush   <= cnt_flush   + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
